// File: rtl/i2s_transmitter.sv
// i2s_transmitter: stereo I2S serialiser with self-generated BCLK/LRCLK
// and a one-entry valid/ready holding buffer.
module i2s_transmitter #(
  parameter int HALF_DIV = 12,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic                i2s_bclk_out,
  output logic                i2s_lrclk_out,
  output logic                i2s_data_out,
  output logic                frame_start_out,
  output logic                underrun_out,
  output logic                busy_out
);

  localparam int DW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(HALF_DIV - 1);
  localparam int PW = 2 * SAMPLE_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [63:0]   shreg;
  logic [PW-1:0] hold;
  logic [PW-1:0] last;
  logic          full;

  logic          tick;
  logic          fall;
  logic          wrap;
  logic          run_like;
  logic          load_en;
  logic          accept;
  logic          full_nxt;
  logic [5:0]    bit_inc;
  logic [PW-1:0] pair;
  logic [63:0]   frame;

  function automatic logic [31:0] slot(input logic [SAMPLE_W-1:0] s);
    logic [31:0] t;
    t = '0;
    t[30 -: SAMPLE_W] = s;
    return t;
  endfunction

  always_comb begin
    tick     = (state != IDLE) && (div_cnt == DIV_TC);
    fall     = tick && i2s_bclk_out;
    wrap     = fall && (bit_cnt == 6'd63);
    run_like = (state == RUN) || ((state == DRAIN) && enable_in);
    load_en  = ((state == IDLE) && enable_in) || (wrap && run_like);
    accept   = valid_in && ready_out;
    // a pair accepted during a load is kept for the next frame
    full_nxt = accept || (full && !load_en);
    pair     = full ? hold : last;
    frame    = {slot(pair[PW-1 -: SAMPLE_W]), slot(pair[SAMPLE_W-1:0])};
    bit_inc  = bit_cnt + 6'd1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      hold            <= '0;
      last            <= '0;
      full            <= 1'b0;
      ready_out       <= 1'b1;
      i2s_bclk_out    <= 1'b0;
      i2s_lrclk_out   <= 1'b0;
      i2s_data_out    <= 1'b0;
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
      full            <= full_nxt;
      ready_out       <= ~full_nxt;
      if (accept)
        hold <= {left_in, right_in};
      if (load_en) begin
        frame_start_out <= 1'b1;
        if (full)
          last <= hold;
        else
          underrun_out <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          div_cnt       <= '0;
          bit_cnt       <= '0;
          i2s_bclk_out  <= 1'b0;
          i2s_lrclk_out <= 1'b0;
          i2s_data_out  <= 1'b0;
          if (enable_in) begin
            state        <= RUN;
            busy_out     <= 1'b1;
            shreg        <= frame;
            i2s_data_out <= frame[63];
          end
        end
        RUN, DRAIN: begin
          if ((state == RUN) && !enable_in)
            state <= DRAIN;
          else if ((state == DRAIN) && enable_in)
            state <= RUN;
          if (tick) begin
            div_cnt      <= '0;
            i2s_bclk_out <= ~i2s_bclk_out;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
          if (fall) begin
            bit_cnt       <= bit_inc;
            i2s_lrclk_out <= bit_inc[5];
            if (wrap && run_like) begin
              shreg        <= frame;
              i2s_data_out <= frame[63];
            end else if (wrap) begin
              state        <= IDLE;
              busy_out     <= 1'b0;
              shreg        <= '0;
              i2s_data_out <= 1'b0;
            end else begin
              shreg        <= shreg << 1;
              i2s_data_out <= shreg[62];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: randomized scoreboard bench for i2s_transmitter;
// frames are deserialised on BCLK rises and compared to a pair-level model.
module tb_i2s_transmitter;
  localparam int HD = 12;
  localparam int SW = 16;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          enable_in = 0;
  logic [SW-1:0] left_in = '0;
  logic [SW-1:0] right_in = '0;
  logic          valid_in = 0;
  logic          ready_out;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          frame_start_out;
  logic          underrun_out;
  logic          busy_out;

  i2s_transmitter #(.HALF_DIV(HD), .SAMPLE_W(SW)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .enable_in(enable_in),
    .left_in(left_in),
    .right_in(right_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .i2s_bclk_out(bclk),
    .i2s_lrclk_out(lrclk),
    .i2s_data_out(sdata),
    .frame_start_out(frame_start_out),
    .underrun_out(underrun_out),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [31:0] p);
    logic [63:0] l;
    logic [63:0] r;
    l = 64'(p[31:16]);
    r = 64'(p[15:0]);
    return (l << (63 - SW)) | (r << (31 - SW));
  endfunction

  // scoreboard state
  logic [31:0] q[$];
  logic [31:0] pend;
  logic        pend_v = 0;
  logic [31:0] last_p = '0;
  logic [63:0] exp_f = '0;
  logic [63:0] rx = '0;
  logic        collecting = 0;
  int          nrise = 0;
  int          cyc = 0;
  int          fs_count = 0;
  int          frames_done = 0;
  int          ur_seen = 0;
  logic        fs_run = 0;
  int          fs_cyc = 0;
  logic        lat_arm = 0;
  int          lat_cyc = 0;
  int          rise_cyc = 0;
  logic        lr_bad = 0;
  logic        per_bad = 0;
  logic        bclk_q = 0;
  logic        busy_q = 0;

  always @(negedge clk) begin
    logic exp_ur;
    cyc++;
    if (!rst_n) begin
      q.delete();
      pend_v = 0;
      last_p = '0;
      collecting = 0;
      lat_arm = 0;
      fs_run = 0;
      bclk_q = 0;
      busy_q = 0;
    end else begin
      exp_ur = 0;
      if (frame_start_out) begin
        fs_count++;
        if (collecting) chk("frame_len", 64'(nrise), 64);
        if (fs_run) chk("fs_period", 64'(cyc - fs_cyc), 64'(32 * 2 * 2 * HD));
        fs_run = 1;
        fs_cyc = cyc;
        exp_ur = (q.size() == 0);
        if (!exp_ur) last_p = q.pop_front();
        exp_f = exp_frame(last_p);
        collecting = 1;
        nrise = 0;
        rx = '0;
        lr_bad = 0;
        per_bad = 0;
      end
      if (frame_start_out || underrun_out)
        chk("underrun", 64'(underrun_out), 64'(frame_start_out && exp_ur));
      if (underrun_out) ur_seen++;
      if (pend_v) q.push_back(pend);
      pend_v = 0;
      chk("ready", 64'(ready_out), 64'(q.size() == 0));
      if (valid_in && ready_out) begin
        pend_v = 1;
        pend = {left_in, right_in};
      end
      if (busy_out && !busy_q) begin
        lat_arm = 1;
        lat_cyc = cyc;
      end
      if (!busy_out) fs_run = 0;
      if (bclk && !bclk_q) begin
        if (lat_arm) chk("first_rise", 64'(cyc - lat_cyc), 64'(HD));
        lat_arm = 0;
        if (collecting) begin
          if (nrise > 0 && (cyc - rise_cyc) != 2 * HD) per_bad = 1;
          if (lrclk != (nrise >= 32)) lr_bad = 1;
          rx = {rx[62:0], sdata};
          nrise++;
          if (nrise == 64) begin
            chk("frame", rx, exp_f);
            chk("lrclk", 64'(lr_bad), 0);
            chk("bclk_period", 64'(per_bad), 0);
            collecting = 0;
            frames_done++;
          end
        end
        rise_cyc = cyc;
      end
      bclk_q = bclk;
      busy_q = busy_out;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r,
                      input logic keep);
    int t = 0;
    left_in = l;
    right_in = r;
    valid_in = 1;
    while (!ready_out && t < 4000) begin
      step(1);
      t++;
    end
    chk("push_wait", 64'(ready_out), 1);
    step(1);
    if (!keep) valid_in = 0;
  endtask

  task automatic wait_fd(input int target);
    int t = 0;
    while (frames_done < target && t < 8000) begin
      step(1);
      t++;
    end
    chk("wait_frames", 64'(frames_done >= target), 1);
  endtask

  task automatic wait_fs_change();
    int f0 = fs_count;
    int t = 0;
    while (fs_count == f0 && t < 4000) begin
      step(1);
      t++;
    end
    chk("wait_fs", 64'(fs_count != f0), 1);
  endtask

  task automatic wait_rise(input int k);
    int t = 0;
    while (!(collecting && nrise >= k) && t < 4000) begin
      step(1);
      t++;
    end
    chk("wait_rise", 64'(collecting && nrise >= k), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_out && t < 4000) begin
      step(1);
      t++;
    end
    chk("wait_idle", 64'(busy_out), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ur0;
    int fd0;
    int fs0;
    int hi;
    // reset held with enable high
    rst_n = 0;
    enable_in = 1;
    step(3);
    chk("rst_bclk", 64'(bclk), 0);
    chk("rst_lrclk", 64'(lrclk), 0);
    chk("rst_data", 64'(sdata), 0);
    chk("rst_ready", 64'(ready_out), 1);
    chk("rst_busy", 64'(busy_out), 0);
    rst_n = 1;
    wait_rise(10);
    enable_in = 0;
    wait_idle();

    // one pair, then three underrun frames
    push(16'hA5C3, 16'h8001, 0);
    step(2);
    ur0 = ur_seen;
    fd0 = frames_done;
    enable_in = 1;
    wait_fd(fd0 + 4);
    chk("underrun_cnt", 64'(ur_seen - ur0), 3);

    // backpressure with valid held high
    push(16'h1357, 16'h2468, 1);
    chk("bp_ready_low", 64'(ready_out), 0);
    push(16'hFACE, 16'h0BAD, 0);
    fd0 = frames_done;
    wait_fd(fd0 + 3);

    // randomized pairs and gaps
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(0, 1500));
      push(SW'($urandom), SW'($urandom), 0);
    end
    wait_fd(frames_done + 2);

    // drain from early in a frame
    wait_fs_change();
    wait_rise(11);
    enable_in = 0;
    fs0 = fs_count;
    fd0 = frames_done;
    wait_idle();
    chk("drain_bclk", 64'(bclk), 0);
    chk("drain_no_fs", 64'(fs_count), 64'(fs0));
    chk("drain_done", 64'(frames_done), 64'(fd0 + 1));
    step(30);
    chk("drain_quiet", 64'(bclk), 0);

    // asynchronous reset mid-frame
    push(16'h1234, 16'hFEDC, 0);
    enable_in = 1;
    wait_fs_change();
    wait_rise(41);
    #1;
    rst_n = 0;
    #1;
    chk("arst_bclk", 64'(bclk), 0);
    chk("arst_lrclk", 64'(lrclk), 0);
    chk("arst_data", 64'(sdata), 0);
    chk("arst_fs", 64'(frame_start_out), 0);
    chk("arst_ur", 64'(underrun_out), 0);
    chk("arst_ready", 64'(ready_out), 1);
    chk("arst_busy", 64'(busy_out), 0);
    enable_in = 0;
    step(3);
    rst_n = 1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bclk || busy_out || sdata) hi++;
    end
    chk("arst_quiet", 64'(hi), 0);
    chk("arst_ready_after", 64'(ready_out), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
